// File: rtl/alu_pkg.sv
// Shared constants for the ALU arithmetic slice.
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int CLA_BLOCK = 4;

    // Value of cin selecting each operation.
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage : alu_pkg

// File: rtl/cla_4bit_block.sv
// 4-bit carry-lookahead group: local sum bits plus group generate/propagate
// for the second-level lookahead in the parent.
module cla_4bit_block (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       g_grp,
    output logic       p_grp,
    output logic       c3
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    // Flat lookahead inside the group: every carry comes from g/p and c_in.
    always_comb begin
        g     = a & b;
        p     = a ^ b;
        c[0]  = c_in;
        c[1]  = g[0] | (p[0] & c_in);
        c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
        c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c_in);
        s     = p ^ c;
        g_grp = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
        p_grp = &p;
        c3    = c[3];
    end

endmodule : cla_4bit_block

// File: rtl/cla_32bit_addsub.sv
// 32-bit two-level carry-lookahead adder/subtractor with registered result,
// carry out and signed compare flags (neq, lt). One-cycle latency, accepts a
// new operation every clock.
module cla_32bit_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int BLOCK = CLA_BLOCK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             neq,
    output logic             lt
);

    localparam int NGRP = WIDTH / BLOCK;

    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] s_next;
    logic [NGRP-1:0]  grp_g;
    logic [NGRP-1:0]  grp_p;
    logic [NGRP-1:0]  grp_c3;
    logic [NGRP:0]    grp_cin;
    logic             c31;
    logic             cout_next;
    logic             ovf;

    logic [WIDTH-1:0] sum_d,  sum_q;
    logic             cout_d, cout_q;
    logic             neq_d,  neq_q;
    logic             lt_d,   lt_q;

    // Subtract is a + ~b + 1; the +1 is the carry into bit 0 (cin itself).
    assign bx = b ^ {WIDTH{cin == MODE_SUB}};

    for (genvar gi = 0; gi < NGRP; gi++) begin : g_blk
        cla_4bit_block u_blk (
            .a     (a[gi*BLOCK +: BLOCK]),
            .b     (bx[gi*BLOCK +: BLOCK]),
            .c_in  (grp_cin[gi]),
            .s     (s_next[gi*BLOCK +: BLOCK]),
            .g_grp (grp_g[gi]),
            .p_grp (grp_p[gi]),
            .c3    (grp_c3[gi])
        );
    end

    // Second-level lookahead: each group carry is a flat sum of products of
    // group G/P and cin, so no carry ripples from one group to the next.
    always_comb begin
        logic term;
        term       = 1'b0;
        grp_cin    = '0;
        grp_cin[0] = cin;
        for (int i = 1; i <= NGRP; i++) begin
            term = cin;
            for (int k = 0; k < i; k++) begin
                term = term & grp_p[k];
            end
            grp_cin[i] = term;
            for (int j = 0; j < i; j++) begin
                term = grp_g[j];
                for (int k = j + 1; k < i; k++) begin
                    term = term & grp_p[k];
                end
                grp_cin[i] = grp_cin[i] | term;
            end
        end
    end

    assign c31       = grp_c3[NGRP-1];
    assign cout_next = grp_cin[NGRP];
    assign ovf       = c31 ^ cout_next;

    // Next register values: result, carry out and overflow-corrected flags.
    always_comb begin
        sum_d  = s_next;
        cout_d = cout_next;
        neq_d  = |s_next;
        lt_d   = s_next[WIDTH-1] ^ ovf;
    end

    // Output registers; async reset drops any in-flight result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            neq_q  <= 1'b0;
            lt_q   <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            neq_q  <= neq_d;
            lt_q   <= lt_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign neq  = neq_q;
    assign lt   = lt_q;

endmodule : cla_32bit_addsub

// File: tb/tb_cla_32bit_addsub.sv
// Self-checking bench for cla_32bit_addsub: reset behaviour, directed
// vectors with hand-computed results, and a back-to-back random run.
module tb_cla_32bit_addsub;
    import alu_pkg::*;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
        logic        neq;
        logic        lt;
        string       tag;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
    logic        neq;
    logic        lt;

    int n_cmp;
    int n_err;

    logic [34:0] exp_q[$];
    vec_t        dir_vecs[11];

    cla_32bit_addsub dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .sum  (sum),
        .cout (cout),
        .neq  (neq),
        .lt   (lt)
    );

    // Clock: 10 ns period, first rising edge at 5 ns.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [34:0] got, input logic [34:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: 33-bit add for carry, sign rule for signed overflow.
    function automatic logic [34:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic mc);
        logic [31:0] bb;
        logic [32:0] full;
        logic        v;
        bb   = mc ? ~mb : mb;
        full = {1'b0, ma} + {1'b0, bb} + {32'd0, mc};
        v    = (ma[31] == bb[31]) && (full[31] != ma[31]);
        return {full[31:0], full[32], (full[31:0] != 32'd0), full[31] ^ v};
    endfunction

    task automatic drive(input logic [31:0] da, input logic [31:0] db, input logic dc);
        a   = da;
        b   = db;
        cin = dc;
    endtask

    task automatic check_all(input string tag, input logic [31:0] es, input logic ec,
                             input logic en, input logic el);
        check_val({tag, ".sum"},  {3'b0, sum},   {3'b0, es});
        check_val({tag, ".cout"}, {34'b0, cout}, {34'b0, ec});
        check_val({tag, ".neq"},  {34'b0, neq},  {34'b0, en});
        check_val({tag, ".lt"},   {34'b0, lt},   {34'b0, el});
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;
        logic [34:0] exp_v;
        logic [31:0] edge_vals[4];

        n_cmp = 0;
        n_err = 0;
        edge_vals[0] = 32'h0000_0000;
        edge_vals[1] = 32'hFFFF_FFFF;
        edge_vals[2] = 32'h8000_0000;
        edge_vals[3] = 32'h7FFF_FFFF;

        dir_vecs[0]  = '{32'd14,         32'd1,          MODE_SUB, 32'd13,         1'b1, 1'b1, 1'b0, "sub14_1"};
        dir_vecs[1]  = '{32'd753,        32'd753,        MODE_SUB, 32'd0,          1'b1, 1'b0, 1'b0, "sub_eq"};
        dir_vecs[2]  = '{32'd0,          32'd0,          MODE_SUB, 32'd0,          1'b1, 1'b0, 1'b0, "sub_zero"};
        dir_vecs[3]  = '{32'd5,          32'd6,          MODE_SUB, 32'hFFFF_FFFF,  1'b0, 1'b1, 1'b1, "sub_lt"};
        dir_vecs[4]  = '{32'd999,        32'd0,          MODE_ADD, 32'd999,        1'b0, 1'b1, 1'b0, "add999"};
        dir_vecs[5]  = '{32'hFFFF_F5F9,  32'd125,        MODE_ADD, 32'hFFFF_F676,  1'b0, 1'b1, 1'b1, "add_neg"};
        dir_vecs[6]  = '{32'h7FFF_FFFF,  32'd1,          MODE_ADD, 32'h8000_0000,  1'b0, 1'b1, 1'b0, "add_ovf"};
        dir_vecs[7]  = '{32'h8000_0000,  32'd1,          MODE_SUB, 32'h7FFF_FFFF,  1'b1, 1'b1, 1'b1, "sub_ovf"};
        dir_vecs[8]  = '{32'hFFFF_FFFF,  32'd1,          MODE_ADD, 32'd0,          1'b1, 1'b0, 1'b0, "add_wrap"};
        dir_vecs[9]  = '{32'hFFFF_FFFD,  32'd2,          MODE_SUB, 32'hFFFF_FFFB,  1'b1, 1'b1, 1'b1, "sub_m3_2"};
        dir_vecs[10] = '{32'd2,          32'hFFFF_FFFD,  MODE_SUB, 32'd5,          1'b0, 1'b1, 1'b0, "sub_2_m3"};

        // Reset asserted from time 0 with arbitrary inputs; checked before any clock edge.
        rst = 1'b1;
        drive(32'hDEAD_BEEF, 32'h1234_5678, MODE_ADD);
        #2;
        check_all("reset0", 32'd0, 1'b0, 1'b0, 1'b0);

        // Release reset between edges.
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors: drive just after an edge, check just after the next.
        @(posedge clk);
        #1;
        for (int i = 0; i < 11; i++) begin
            drive(dir_vecs[i].a, dir_vecs[i].b, dir_vecs[i].cin);
            @(posedge clk);
            #1;
            check_all(dir_vecs[i].tag, dir_vecs[i].sum, dir_vecs[i].cout,
                      dir_vecs[i].neq, dir_vecs[i].lt);
        end

        // Asynchronous reset mid-cycle: outputs currently hold a non-zero result.
        drive(32'd100, 32'd200, MODE_ADD);
        #1;
        rst = 1'b1;
        #1;
        check_all("reset_async", 32'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_all("reset_hold", 32'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #2;
        check_all("reset_release", 32'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_all("first_capture", 32'd300, 1'b0, 1'b1, 1'b0);

        // Back-to-back random run: a new operation each cycle, result one cycle later.
        for (int i = 0; i < 1000; i++) begin
            ra = (($urandom_range(0, 7)) == 0) ? edge_vals[$urandom_range(0, 3)] : 32'($urandom);
            rb = (($urandom_range(0, 7)) == 0) ? edge_vals[$urandom_range(0, 3)] : 32'($urandom);
            if ($urandom_range(0, 15) == 0) rb = ra;
            rc = 1'($urandom_range(0, 1));
            drive(ra, rb, rc);
            exp_q.push_back(model(ra, rb, rc));
            @(posedge clk);
            #1;
            exp_v = exp_q.pop_front();
            check_val("rand", {sum, cout, neq, lt}, exp_v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_cla_32bit_addsub
